// File: rtl/alu_mdu_pkg.sv
// -----------------------------------------------------------------------------
// alu_mdu_pkg
// Shared encodings for the EX-stage ALU and the multiply/divide unit.
//   ALU_*  : 4-bit ALU operation codes driven on alu_mdu.oper
//   MD_*   : 2-bit multiply/divide unit operation codes driven on alu_mdu.md_op
// FSM state encodings are kept local to the modules that own them.
// -----------------------------------------------------------------------------
package alu_mdu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_NOR = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;
    localparam logic [3:0] ALU_SL  = 4'd8;
    localparam logic [3:0] ALU_SR  = 4'd9;

    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_DIV  = 2'd1;
    localparam logic [1:0] MD_MTHI = 2'd2;
    localparam logic [1:0] MD_MTLO = 2'd3;

endpackage

// File: rtl/alu_mdu_iter.sv
// -----------------------------------------------------------------------------
// alu_mdu_iter
// Iterative multiply / restoring divide datapath with its control FSM.
// One result bit per cycle for WIDTH cycles (CALC), one cycle of sign
// fix-up (FIX, during which wr_en_o is high and wr_hi_o/wr_lo_o carry the
// final HI/LO values), then one DONE cycle that pulses done_o.
// Ports:
//   clk, rst_i        clock, synchronous active-high reset (aborts any op)
//   start_i           begin MUL/DIV; honoured only while idle_o is high
//   is_div_i          1 = divide, 0 = multiply
//   sign_i            1 = signed operands
//   a_i, b_i          operands (captured at start)
//   busy_o            high in CALC and FIX
//   done_o            high in DONE
//   idle_o            high in IDLE
//   wr_en_o           high in FIX: HI/LO owner should load wr_hi_o/wr_lo_o
//   wr_hi_o, wr_lo_o  final HI/LO values
// -----------------------------------------------------------------------------
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             sign_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             idle_o,
    output logic             wr_en_o,
    output logic [WIDTH-1:0] wr_hi_o,
    output logic [WIDTH-1:0] wr_lo_o
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SH_W-1:0]    cnt_q, cnt_d;
    // MUL: {partial product high, multiplier being shifted out}
    // DIV: {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;     // |b|: multiplicand or divisor
    logic [WIDTH-1:0]   araw_q, araw_d;   // raw dividend, returned on divide by zero
    logic               div_q, div_d;
    logic               neg_q, neg_d;     // product / quotient is negative
    logic               rneg_q, rneg_d;   // remainder takes the dividend's sign

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign a_neg = sign_i & a_i[WIDTH-1];
    assign b_neg = sign_i & b_i[WIDTH-1];
    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right; the carry enters at the top.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // trial-subtract, keep the difference only if it did not borrow.
    logic [WIDTH:0]     div_trial, div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, opb_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ok};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        araw_d  = araw_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        idle_o  = 1'b0;
        wr_en_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_o = 1'b1;
                if (start_i) begin
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    opb_d   = b_mag;
                    araw_d  = a_i;
                    div_d   = is_div_i;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy_o = 1'b1;
                acc_d  = div_q ? div_next : mul_next;
                cnt_d  = cnt_q + SH_W'(1);
                if (cnt_q == SH_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy_o  = 1'b1;
                wr_en_o = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sign fix-up of the unsigned magnitude result.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        wr_hi_o = prod_fix[2*WIDTH-1:WIDTH];
        wr_lo_o = prod_fix[WIDTH-1:0];
        if (div_q) begin
            if (opb_q == '0) begin
                // Divide by zero does not trap: all-ones quotient, dividend as remainder.
                wr_hi_o = araw_q;
                wr_lo_o = '1;
            end else begin
                wr_hi_o = rem_fix;
                wr_lo_o = quo_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            araw_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            araw_q  <= araw_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
// EX-stage ALU plus multiply/divide unit with architectural HI/LO registers.
// WIDTH must be a power of two, at least 8.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   a, b       operands; shift amount comes from a[SH_W-1:0], shifted value is b
//   oper       ALU op (ALU_* codes), sign selects signed SLT / arithmetic SR
//   result     combinational ALU result (undefined opers give 0)
//   md_op      MD_MUL / MD_DIV / MD_MTHI / MD_MTLO
//   md_start   MD request, sampled on the clock edge, only accepted in IDLE
//   md_busy    MD unit occupied (stall MFHI/MFLO and new MD ops)
//   md_done    one-cycle pulse after HI/LO were written by MUL/DIV
//   hi, lo     HI/LO registers
// -----------------------------------------------------------------------------
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       oper,
    input  logic             sign,
    output logic [WIDTH-1:0] result,
    input  logic [1:0]       md_op,
    input  logic             md_start,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SH_W = $clog2(WIDTH);

    // ---------------- combinational ALU ----------------
    logic [SH_W-1:0] shamt;
    logic            lt;

    assign shamt = a[SH_W-1:0];
    assign lt    = sign ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        result = '0;
        case (oper)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_LUI: result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SL:  result = b << shamt;
            ALU_SR:  result = sign ? $unsigned($signed(b) >>> shamt) : (b >> shamt);
            default: result = '0;
        endcase
    end

    // ---------------- multiply / divide ----------------
    logic             md_idle, md_wr_en;
    logic [WIDTH-1:0] md_wr_hi, md_wr_lo;
    logic             md_calc_start;
    logic             mt_hi, mt_lo;

    assign md_calc_start = md_start & ((md_op == MD_MUL) | (md_op == MD_DIV));
    // Moves only land in IDLE; while busy or in DONE they are dropped.
    assign mt_hi = md_start & md_idle & (md_op == MD_MTHI);
    assign mt_lo = md_start & md_idle & (md_op == MD_MTLO);

    alu_mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_i    (rst),
        .start_i  (md_calc_start),
        .is_div_i (md_op == MD_DIV),
        .sign_i   (sign),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .idle_o   (md_idle),
        .wr_en_o  (md_wr_en),
        .wr_hi_o  (md_wr_hi),
        .wr_lo_o  (md_wr_lo)
    );

    logic [WIDTH-1:0] hi_q, lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_wr_en) begin
            hi_q <= md_wr_hi;
            lo_q <= md_wr_lo;
        end else begin
            if (mt_hi) hi_q <= a;
            if (mt_lo) lo_q <= a;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
